// File: rtl/wb_completion_arbiter_pkg.sv
// Shared types and encodings for the writeback completion arbiter.
package wb_completion_arbiter_pkg;

    localparam int WORD_SIZE    = 32;
    localparam int ROB_ID_WIDTH = 7;

    typedef enum logic [1:0] {
        INSTR_TYPE_ALU   = 2'd0,
        INSTR_TYPE_LOAD  = 2'd1,
        INSTR_TYPE_STORE = 2'd2,
        INSTR_TYPE_MUL   = 2'd3
    } instr_type_e;

    // One completed instruction as written into the reorder buffer
    typedef struct packed {
        instr_type_e                instruction_type;
        logic [WORD_SIZE-1:0]       pc;
        logic                       exception;
        logic [WORD_SIZE-1:0]       virtual_addr_exception;
        logic [WORD_SIZE-1:0]       result;
        logic [ROB_ID_WIDTH-1:0]    rob_id;
    } wb_entry_t;

endpackage

// File: rtl/wb_completion_arbiter_fifo.sv
// Two-write, one-read circular buffer of completion entries.
// Port 1 is only ever used together with port 0 and lands in the slot after it.
module completion_fifo
    import wb_completion_arbiter_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic            i_flush,
    input  logic            i_wr0_en,
    input  wb_entry_t       i_wr0_data,
    input  logic            i_wr1_en,
    input  wb_entry_t       i_wr1_data,
    input  logic            i_rd_en,
    output wb_entry_t       o_rd_data,
    output logic [CW-1:0]   o_count
);

    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    wb_entry_t        r_mem [DEPTH];

    logic [PW-1:0]    w_wr1_idx;
    logic [DEPTH-1:0] w_sel0;
    logic [DEPTH-1:0] w_sel1;

    assign w_wr1_idx = r_wr_ptr + PW'(1);

    // Per-slot write-select decode for both write ports
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_sel
            assign w_sel0[gi] = i_wr0_en && (r_wr_ptr  == PW'(gi));
            assign w_sel1[gi] = i_wr1_en && (w_wr1_idx == PW'(gi));
        end
    endgenerate

    // Entry storage; cleared on reset so the head reads as all-zero while reset is held
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_sel0[i]) begin
                    r_mem[i] <= i_wr0_data;
                end else if (w_sel1[i]) begin
                    r_mem[i] <= i_wr1_data;
                end
            end
        end
    end

    // Pointer and occupancy bookkeeping; flush empties the queue without touching storage
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PW'(i_wr0_en) + PW'(i_wr1_en);
            r_rd_ptr <= r_rd_ptr + PW'(i_rd_en);
            r_count  <= r_count + CW'(i_wr0_en) + CW'(i_wr1_en) - CW'(i_rd_en);
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_count   = r_count;

endmodule

// File: rtl/wb_completion_arbiter.sv
// Writeback completion arbiter: merges memory-pipe and multiplier completions
// into an in-order queue drained one per cycle into the ROB write port.
module wb_completion_arbiter
    import wb_completion_arbiter_pkg::*;
#(
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic                     i_flush,
    input  logic                     i_mem_valid,
    input  logic [1:0]               i_mem_instruction_type,
    input  logic [WORD_SIZE-1:0]     i_mem_pc,
    input  logic                     i_mem_exception,
    input  logic [WORD_SIZE-1:0]     i_mem_virtual_addr_exception,
    input  logic [WORD_SIZE-1:0]     i_mem_result,
    input  logic [ROB_ID_WIDTH-1:0]  i_mem_rob_id,
    input  logic                     i_mul_valid,
    input  logic [WORD_SIZE-1:0]     i_mul_pc,
    input  logic [WORD_SIZE-1:0]     i_mul_result,
    input  logic [ROB_ID_WIDTH-1:0]  i_mul_rob_id,
    output logic                     o_stall,
    output logic                     o_rob_wr_valid,
    input  logic                     i_rob_wr_ready,
    output logic [1:0]               o_rob_wr_instruction_type,
    output logic [WORD_SIZE-1:0]     o_rob_wr_pc,
    output logic                     o_rob_wr_exception,
    output logic [WORD_SIZE-1:0]     o_rob_wr_virtual_addr_exception,
    output logic [WORD_SIZE-1:0]     o_rob_wr_result,
    output logic [ROB_ID_WIDTH-1:0]  o_rob_wr_rob_id
);

    localparam int CW = $clog2(QUEUE_DEPTH) + 1;

    logic [CW-1:0] w_count;
    logic          w_acc_mem;
    logic          w_acc_mul;
    logic          w_deq;
    wb_entry_t     w_mem_entry;
    wb_entry_t     w_mul_entry;
    wb_entry_t     w_head;

    // Stall depends only on registered occupancy: two free slots are always guaranteed
    assign o_stall        = (w_count > CW'(QUEUE_DEPTH - 2));
    assign o_rob_wr_valid = (w_count != '0);

    assign w_acc_mem = i_mem_valid && !o_stall && !i_flush;
    assign w_acc_mul = i_mul_valid && !o_stall && !i_flush;
    assign w_deq     = o_rob_wr_valid && i_rob_wr_ready && !i_flush;

    assign w_mem_entry = '{
        instruction_type:       instr_type_e'(i_mem_instruction_type),
        pc:                     i_mem_pc,
        exception:              i_mem_exception,
        virtual_addr_exception: i_mem_virtual_addr_exception,
        result:                 i_mem_result,
        rob_id:                 i_mem_rob_id
    };

    // Multiplier completions never fault
    assign w_mul_entry = '{
        instruction_type:       INSTR_TYPE_MUL,
        pc:                     i_mul_pc,
        exception:              1'b0,
        virtual_addr_exception: '0,
        result:                 i_mul_result,
        rob_id:                 i_mul_rob_id
    };

    // Port 0 takes mem when present, else mul; port 1 carries mul only on dual accept
    completion_fifo #(
        .DEPTH      (QUEUE_DEPTH)
    ) u_fifo (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_flush    (i_flush),
        .i_wr0_en   (w_acc_mem || w_acc_mul),
        .i_wr0_data (w_acc_mem ? w_mem_entry : w_mul_entry),
        .i_wr1_en   (w_acc_mem && w_acc_mul),
        .i_wr1_data (w_mul_entry),
        .i_rd_en    (w_deq),
        .o_rd_data  (w_head),
        .o_count    (w_count)
    );

    assign o_rob_wr_instruction_type       = w_head.instruction_type;
    assign o_rob_wr_pc                     = w_head.pc;
    assign o_rob_wr_exception              = w_head.exception;
    assign o_rob_wr_virtual_addr_exception = w_head.virtual_addr_exception;
    assign o_rob_wr_result                 = w_head.result;
    assign o_rob_wr_rob_id                 = w_head.rob_id;

endmodule

// File: doc/wb_completion_arbiter.md
# wb_completion_arbiter

Writeback-stage completion arbiter, sitting directly downstream of the memory/writeback pipeline register and the multiplier pipe's final stage. Each cycle it accepts up to two completed instructions and buffers them in a small in-order queue. It then drains them one per cycle through the single reorder-buffer write port using a valid/ready handshake. It back-pressures both producers when it cannot guarantee room for two entries.

## Interface
- WORD_SIZE, 32, data/address width
- ROB_ID_WIDTH, 7, reorder-buffer tag width
- QUEUE_DEPTH, 4, completion queue entries; power of two, at least 2

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- flush  in  1  synchronous pipeline flush, active-high
- mem_valid  in  1  memory-pipe completion present
- mem_instruction_type  in  2  instruction class
- mem_pc  in  WORD_SIZE  instruction PC
- mem_exception  in  1  instruction raised an exception
- mem_virtual_addr_exception  in  WORD_SIZE  faulting virtual address
- mem_result  in  WORD_SIZE  ALU/load result
- mem_rob_id  in  ROB_ID_WIDTH  ROB tag
- mul_valid  in  1  multiplier completion present
- mul_pc  in  WORD_SIZE  instruction PC
- mul_result  in  WORD_SIZE  product
- mul_rob_id  in  ROB_ID_WIDTH  ROB tag
- stall  out  1  producers must hold; inputs are ignored while high
- rob_wr_valid  out  1  head entry offered to ROB
- rob_wr_ready  in  1  ROB accepts this cycle
- rob_wr_instruction_type, rob_wr_pc, rob_wr_exception, rob_wr_virtual_addr_exception, rob_wr_result, rob_wr_rob_id  out  2/WORD_SIZE/1/WORD_SIZE/WORD_SIZE/ROB_ID_WIDTH  head entry fields

## Operation
- Entry: {instruction_type, pc, exception, virtual_addr_exception, result, rob_id}.
- Multiplier entries use instruction_type = INSTR_TYPE_MUL, exception = 0 and virtual_addr_exception = 0.
- Accept:
  - acc_mem = mem_valid && !stall && !flush
  - acc_mul = mul_valid && !stall && !flush
- Enqueue order on a single cycle: the mem entry goes at wr_ptr, then the mul entry at wr_ptr+1. If only one source is accepted, it goes at wr_ptr.
- Dequeue: deq = rob_wr_valid && rob_wr_ready; rd_ptr advances by 1.
- count_next = count + acc_mem + acc_mul − deq. Enqueue and dequeue in the same cycle are legal.
- Count register width is clog2(QUEUE_DEPTH)+1. Pointers are clog2(QUEUE_DEPTH) bits and wrap modulo QUEUE_DEPTH.
- stall = (count > QUEUE_DEPTH−2). This is combinational from registered count only, with no path from valid or ready inputs.
- rob_wr_valid = (count != 0). The rob_wr_* fields come from the head entry and are combinational from storage and rd_ptr. Field values are don't-care when rob_wr_valid = 0.
- Flush: count, wr_ptr and rd_ptr are set to 0 at the next edge. All inputs are dropped and no dequeue occurs in that cycle. Entry storage need not be cleared.
- Reset (asserted low, any time): count, wr_ptr and rd_ptr go to 0 and all storage goes to 0 asynchronously.
  - Outputs during reset: stall = 0, rob_wr_valid = 0, all rob_wr_* fields = 0.
- Overflow cannot occur by construction. Inputs that arrive while stall is high are ignored, not queued.

## Timing
- Latency: an entry accepted at edge N is presented on rob_wr_* in cycle N+1 if the queue was empty.
- Throughput: one ROB write per cycle sustained. A burst of two accepted completions per cycle fills the queue, and stall then rises.
- Handshake: once rob_wr_valid rises, the head entry holds stable until the ROB accepts it or a flush/reset occurs.
- stall reflects count after the previous edge. It deasserts in the cycle after count drops to QUEUE_DEPTH−2 or below.

## Structure
- Shared package:
  - wb_entry_t packed struct
  - INSTR_TYPE_* encodings, including INSTR_TYPE_MUL
  - WORD_SIZE and ROB_ID_WIDTH defaults
- Sub-module completion_fifo: a two-write-port, one-read-port circular buffer holding count, pointers and storage. The top level owns stall, accept logic and multiplier-entry formatting.

## Test plan
- Single mem completion (pc=0x100, result=0xDEAD, rob_id=5) with ready=1 → rob_wr_valid=1 next cycle with matching fields, then 0 the cycle after.
- Simultaneous mem (rob_id=1) and mul (rob_id=2), ready=1 → ROB sees rob_id 1 then 2 in consecutive cycles; mul entry has exception=0 and type=INSTR_TYPE_MUL.
- ready=0 with a dual-issue completion in each of two cycles → count=4; stall=1 from the cycle after count exceeds 2. A third held input is not queued; releasing ready drains 4 entries in order with wrap-around.
- Queue holds 3 entries and flush=1 with mem_valid=1 → next cycle rob_wr_valid=0, count=0, stall=0; the mem input is dropped.
- reset driven low mid-drain, asynchronously between edges → rob_wr_valid, stall and all rob_wr_* fields become 0 immediately; after reset releases, a new entry emerges with rob_id=9.
- Steady state: one mem completion per cycle for 20 cycles, ready=1 → stall never asserts and the ROB receives all 20 in order.
